// File: rtl/regfile_2w_scoreboard.sv
// Core register file for the pipelined core.
// It has two combinational read ports and two write ports. Port 4 (load/MUL)
// wins over port 3 (ALU) when both write the same address. Each register has a
// busy bit that decode sets at issue. Writeback clears it. The hazard unit uses
// the busy bits for RAW stall detection.
module regfile_2w_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE4,
    input  logic [ADDR_W-1:0] A4,
    input  logic [DATA_W-1:0] WD4,
    input  logic              ISSUE_EN,
    input  logic [ADDR_W-1:0] ISSUE_RD,
    output logic              BUSY1,
    output logic              BUSY2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    // Effective write and issue strobes, after priority and zero-register filtering.
    logic wr3;
    logic wr4;
    logic iss;

    // Read-side views, indexed by port (0 -> A1/RD1/BUSY1, 1 -> A2/RD2/BUSY2).
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];
    logic [1:0]        rbusy;

    // Register 0 is hardwired only when ZERO_REG is set.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    assign wr4 = WE4 && !is_zero(A4);
    // Port 3 yields to port 4 only on an address clash. Otherwise both ports write.
    assign wr3 = WE3 && !(WE4 && (A4 == A3)) && !is_zero(A3);
    assign iss = ISSUE_EN && !is_zero(ISSUE_RD);

    // Register array: cleared on reset, otherwise takes up to two writes at distinct addresses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: reads must return 0 after reset, so the array is cleared here.
            // This keeps the array in flops. A RAM macro would have no reset.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments, so every reader sees the pre-edge value.
            if (wr3) regs[A3] <= WD3;
            if (wr4) regs[A4] <= WD4;
        end
    end

    // Scoreboard next state: writebacks clear, then issue sets (a new producer supersedes the old one).
    always_comb begin
        // NOTE: assign the default first so that no path leaves busy_next unassigned (no latch).
        busy_next = busy;
        if (wr3) busy_next[A3] = 1'b0;
        if (wr4) busy_next[A4] = 1'b0;
        if (iss) busy_next[ISSUE_RD] = 1'b1;
    end

    // Scoreboard register: reset drops every pending producer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign raddr[0] = A1;
    assign raddr[1] = A2;

    // Read ports: stored value, then optional same-cycle forwarding (port 4 last, so it wins), then zero override.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            rbusy[p] = busy[raddr[p]];
            if (BYPASS && wr3 && (A3 == raddr[p])) begin
                rdata[p] = WD3;
                rbusy[p] = 1'b0;
            end
            if (BYPASS && wr4 && (A4 == raddr[p])) begin
                rdata[p] = WD4;
                rbusy[p] = 1'b0;
            end
            if (is_zero(raddr[p])) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign RD1   = rdata[0];
    assign RD2   = rdata[1];
    assign BUSY1 = rbusy[0];
    assign BUSY2 = rbusy[1];

endmodule

// File: tb/tb_regfile_2w_scoreboard.sv
// Testbench for regfile_2w_scoreboard.
// It drives two instances from the same stimulus: one with forwarding, one
// without. A behavioural model of the register contents and the pending set
// predicts the outputs of both instances.
module tb_regfile_2w_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic [ADDR_W-1:0] A1, A2, A3, A4, ISSUE_RD;
    logic [DATA_W-1:0] WD3, WD4;
    logic              WE3, WE4, ISSUE_EN;

    logic [DATA_W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic              busy1_b, busy2_b, busy1_n, busy2_n;

    // Reference state: register contents and the set of pending destinations.
    logic [DATA_W-1:0] m_reg  [DEPTH];
    bit                m_busy [DEPTH];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    regfile_2w_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_byp (
        .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .RD1(rd1_b), .RD2(rd2_b),
        .WE3(WE3), .A3(A3), .WD3(WD3), .WE4(WE4), .A4(A4), .WD4(WD4),
        .ISSUE_EN(ISSUE_EN), .ISSUE_RD(ISSUE_RD), .BUSY1(busy1_b), .BUSY2(busy2_b)
    );

    regfile_2w_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nob (
        .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .RD1(rd1_n), .RD2(rd2_n),
        .WE3(WE3), .A3(A3), .WD3(WD3), .WE4(WE4), .A4(A4), .WD4(WD4),
        .ISSUE_EN(ISSUE_EN), .ISSUE_RD(ISSUE_RD), .BUSY1(busy1_n), .BUSY2(busy2_n)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns 1 if a write lands on address a this cycle. Writes to r0 are dropped, and port 4 wins a clash.
    function automatic bit writes_to(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        return (WE4 && A4 == a) || (WE3 && A3 == a);
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && WE4 && A4 == a) return WD4;
        if (byp && WE3 && A3 == a) return WD3;
        return m_reg[a];
    endfunction

    function automatic logic [DATA_W-1:0] exp_busy(input logic [ADDR_W-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && writes_to(a)) return '0;
        return {31'b0, m_busy[a]};
    endfunction

    // Advance the model by one rising edge, using the inputs that are sampled at that edge.
    task automatic model_update();
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (WE3 && A3 != 0 && !(WE4 && A4 == A3)) begin
                m_reg[A3]  = WD3;
                m_busy[A3] = 1'b0;
            end
            if (WE4 && A4 != 0) begin
                m_reg[A4]  = WD4;
                m_busy[A4] = 1'b0;
            end
            if (ISSUE_EN && ISSUE_RD != 0) m_busy[ISSUE_RD] = 1'b1;
        end
    endtask

    // Compare both instances against the model at the falling edge. Then cross the rising edge.
    task automatic cycle();
        @(negedge CLK);
        if (!RST) begin
            check("rd1_byp",   rd1_b,           exp_rd(A1, 1'b1));
            check("rd2_byp",   rd2_b,           exp_rd(A2, 1'b1));
            check("busy1_byp", {31'b0, busy1_b}, exp_busy(A1, 1'b1));
            check("busy2_byp", {31'b0, busy2_b}, exp_busy(A2, 1'b1));
            check("rd1_nob",   rd1_n,           exp_rd(A1, 1'b0));
            check("rd2_nob",   rd2_n,           exp_rd(A2, 1'b0));
            check("busy1_nob", {31'b0, busy1_n}, exp_busy(A1, 1'b0));
            check("busy2_nob", {31'b0, busy2_n}, exp_busy(A2, 1'b0));
        end
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle();
        RST = 1'b0; WE3 = 1'b0; WE4 = 1'b0; ISSUE_EN = 1'b0;
        A3 = '0; A4 = '0; WD3 = '0; WD4 = '0; ISSUE_RD = '0;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, DEPTH - 1));
        return ADDR_W'($urandom_range(0, 15));
    endfunction

    initial begin
        idle();
        A1 = '0; A2 = '0;
        RST = 1'b1;
        cycle();

        // Reset clears stored data and pending state.
        idle(); WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; cycle();
        idle(); ISSUE_EN = 1'b1; ISSUE_RD = 5'd5; cycle();
        idle(); RST = 1'b1; WE4 = 1'b1; A4 = 5'd5; WD4 = 32'h1234; cycle();
        idle(); A1 = 5'd5; #1;
        check("reset_rd1", rd1_b, 32'h0);
        check("reset_busy1", {31'b0, busy1_b}, 32'h0);
        cycle();

        // Two writes at different addresses in one cycle.
        idle(); WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h11; WE4 = 1'b1; A4 = 5'd9; WD4 = 32'h22; cycle();
        idle(); A1 = 5'd7; A2 = 5'd9; #1;
        check("dual_rd1", rd1_n, 32'h11);
        check("dual_rd2", rd2_n, 32'h22);
        cycle();

        // Both ports write one address: port 4 wins.
        idle(); WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h33; WE4 = 1'b1; A4 = 5'd7; WD4 = 32'h44;
        A1 = 5'd7; #1;
        check("clash_bypass", rd1_b, 32'h44);
        cycle();
        idle(); A1 = 5'd7; #1;
        check("clash_stored", rd1_n, 32'h44);
        cycle();

        // Forwarding versus no forwarding.
        idle(); WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h5; cycle();
        idle(); WE3 = 1'b1; A3 = 5'd3; WD3 = 32'hAB; A1 = 5'd3; #1;
        check("bypass_on", rd1_b, 32'hAB);
        check("bypass_off", rd1_n, 32'h5);
        cycle();
        idle(); A1 = 5'd3; #1;
        check("bypass_off_next", rd1_n, 32'hAB);
        cycle();

        // Register 0 ignores writes and issue.
        idle(); WE4 = 1'b1; A4 = 5'd0; WD4 = 32'hFFFF; ISSUE_EN = 1'b1; ISSUE_RD = 5'd0; A1 = 5'd0; #1;
        check("zero_rd_same", rd1_b, 32'h0);
        check("zero_busy_same", {31'b0, busy1_b}, 32'h0);
        cycle();
        idle(); A1 = 5'd0; #1;
        check("zero_rd_after", rd1_n, 32'h0);
        check("zero_busy_after", {31'b0, busy1_n}, 32'h0);
        cycle();

        // Issue, wait, then write back.
        idle(); ISSUE_EN = 1'b1; ISSUE_RD = 5'd12; cycle();
        idle(); A1 = 5'd12; #1;
        check("sb_busy", {31'b0, busy1_b}, 32'h1);
        cycle(); cycle(); cycle();
        idle(); A1 = 5'd12; WE4 = 1'b1; A4 = 5'd12; WD4 = 32'h99; #1;
        check("sb_wb_busy_byp", {31'b0, busy1_b}, 32'h0);
        check("sb_wb_rd_byp", rd1_b, 32'h99);
        check("sb_wb_busy_nob", {31'b0, busy1_n}, 32'h1);
        cycle();
        idle(); A1 = 5'd12; #1;
        check("sb_after_busy", {31'b0, busy1_n}, 32'h0);
        check("sb_after_rd", rd1_n, 32'h99);
        cycle();

        // Issue and write on the same register in one cycle: the set wins.
        idle(); ISSUE_EN = 1'b1; ISSUE_RD = 5'd8; cycle();
        idle(); WE3 = 1'b1; A3 = 5'd8; WD3 = 32'h77; ISSUE_EN = 1'b1; ISSUE_RD = 5'd8; A1 = 5'd8; cycle();
        idle(); A1 = 5'd8; #1;
        check("coll_rd", rd1_b, 32'h77);
        check("coll_busy", {31'b0, busy1_b}, 32'h1);
        cycle();

        // Random traffic, with an occasional reset.
        for (int n = 0; n < 600; n++) begin
            RST      = ($urandom_range(0, 59) == 0);
            WE3      = $urandom_range(0, 1) == 1;
            WE4      = $urandom_range(0, 2) == 0;
            ISSUE_EN = $urandom_range(0, 1) == 1;
            A1 = rand_addr(); A2 = rand_addr(); A3 = rand_addr(); A4 = rand_addr();
            ISSUE_RD = rand_addr();
            WD3 = $urandom(); WD4 = $urandom();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
